// File: rtl/dram_rr_scheduler_pkg.sv
// Shared types and constants for the three-port DRAM round-robin scheduler.
package dram_rr_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned NPORT = 3;
   localparam int unsigned DW    = 32;
   localparam int unsigned BEW   = 4;

   localparam logic [1:0] PORT_IC  = 2'd0;
   localparam logic [1:0] PORT_DC  = 2'd1;
   localparam logic [1:0] PORT_DBG = 2'd2;

   localparam logic [31:0] DEAD_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/dram_rr_scheduler_rr_pick3.sv
// Combinational 3-way round-robin chooser: first set req bit at or above ptr, mod 3.
module rr_pick3
   import dram_rr_scheduler_pkg::*;
(
   input  logic [NPORT-1:0] req,
   input  logic [1:0]       ptr,
   output logic [1:0]       gnt_idx,
   output logic             any
);

   logic [NPORT-1:0][1:0] w_order;

   // w_order[0] is the highest-priority candidate; lower slots overwrite higher ones
   always_comb begin
      w_order = {PORT_DBG, PORT_DC, PORT_IC};
      gnt_idx = PORT_IC;
      any     = |req;
      case (ptr)
         PORT_DC:  w_order = {PORT_IC, PORT_DBG, PORT_DC};
         PORT_DBG: w_order = {PORT_DC, PORT_IC, PORT_DBG};
         default:  w_order = {PORT_DBG, PORT_DC, PORT_IC};
      endcase
      if (req[w_order[2]]) gnt_idx = w_order[2];
      if (req[w_order[1]]) gnt_idx = w_order[1];
      if (req[w_order[0]]) gnt_idx = w_order[0];
   end

endmodule

// File: rtl/dram_rr_scheduler.sv
// Round-robin sharing of one DRAM port between I-cache, D-cache and debug/loader,
// one transaction outstanding, with response watchdog and per-port grant counters.
module dram_rr_scheduler
   import dram_rr_scheduler_pkg::*;
#(
   parameter int unsigned MEM_SCALE = 27,
   parameter int unsigned TIMEOUT   = 4096,
   parameter logic [31:0] DEAD_DATA = DEAD_DATA_DEF
) (
   input  logic                       clk,
   input  logic                       rst_x,
   input  logic [NPORT-1:0]           req,
   input  logic [NPORT*MEM_SCALE-1:0] addr,
   input  logic [NPORT*DW-1:0]        wdata,
   input  logic [NPORT*BEW-1:0]       we,
   output logic [DW-1:0]              rdata,
   output logic [NPORT-1:0]           valid,
   output logic [NPORT-1:0]           written,
   output logic                       dram_oe,
   output logic [MEM_SCALE-1:0]       dram_addr,
   output logic [DW-1:0]              dram_wdata,
   output logic [BEW-1:0]             dram_we,
   input  logic [DW-1:0]              dram_rdata,
   input  logic                       dram_valid,
   input  logic                       dram_written,
   output logic                       err_timeout,
   output logic                       err_stray,
   output logic [NPORT*DW-1:0]        grant_cnt
);

   localparam int unsigned    WD_W    = 32;
   localparam logic           WD_EN   = (TIMEOUT != 0);
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

   state_t                      r_state, w_state_nxt;
   logic [1:0]                  r_ptr, w_ptr_nxt;
   logic [1:0]                  r_port, w_port_nxt;
   logic                        r_is_wr, w_is_wr_nxt;
   logic [WD_W-1:0]             r_wd, w_wd_nxt;
   logic [DW-1:0]               r_rdata, w_rdata_nxt;
   logic [NPORT-1:0]            r_valid, w_valid_nxt;
   logic [NPORT-1:0]            r_written, w_written_nxt;
   logic                        r_oe, w_oe_nxt;
   logic [MEM_SCALE-1:0]        r_addr, w_addr_nxt;
   logic [DW-1:0]               r_wdata, w_wdata_nxt;
   logic [BEW-1:0]              r_we, w_we_nxt;
   logic                        r_err_to, w_err_to_nxt;
   logic                        r_err_st, w_err_st_nxt;
   logic [NPORT-1:0][DW-1:0]    r_cnt, w_cnt_nxt;

   logic [NPORT-1:0][MEM_SCALE-1:0] w_addr_v;
   logic [NPORT-1:0][DW-1:0]        w_wdata_v;
   logic [NPORT-1:0][BEW-1:0]       w_we_v;
   logic [1:0]                      w_gnt;
   logic                            w_any;
   logic [BEW-1:0]                  w_gnt_we;
   logic                            w_match, w_wrong, w_timeout;

   assign w_addr_v  = addr;
   assign w_wdata_v = wdata;
   assign w_we_v    = we;

   rr_pick3 u_pick (
      .req     (req),
      .ptr     (r_ptr),
      .gnt_idx (w_gnt),
      .any     (w_any)
   );

   // I-cache is read-only: its byte enables never reach DRAM
   assign w_gnt_we  = (w_gnt == PORT_IC) ? '0 : w_we_v[w_gnt];
   assign w_match   = r_is_wr ? dram_written : dram_valid;
   assign w_wrong   = r_is_wr ? dram_valid : dram_written;
   assign w_timeout = WD_EN && (r_wd == WD_LAST);

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_port    <= '0;
         r_is_wr   <= 1'b0;
         r_wd      <= '0;
         r_rdata   <= '0;
         r_valid   <= '0;
         r_written <= '0;
         r_oe      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_we      <= '0;
         r_err_to  <= 1'b0;
         r_err_st  <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_port    <= w_port_nxt;
         r_is_wr   <= w_is_wr_nxt;
         r_wd      <= w_wd_nxt;
         r_rdata   <= w_rdata_nxt;
         r_valid   <= w_valid_nxt;
         r_written <= w_written_nxt;
         r_oe      <= w_oe_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_we      <= w_we_nxt;
         r_err_to  <= w_err_to_nxt;
         r_err_st  <= w_err_st_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_port_nxt    = r_port;
      w_is_wr_nxt   = r_is_wr;
      w_wd_nxt      = r_wd;
      w_rdata_nxt   = r_rdata;
      w_valid_nxt   = '0;
      w_written_nxt = '0;
      w_oe_nxt      = 1'b0;
      w_addr_nxt    = r_addr;
      w_wdata_nxt   = r_wdata;
      w_we_nxt      = r_we;
      w_err_to_nxt  = r_err_to;
      w_err_st_nxt  = r_err_st;
      w_cnt_nxt     = r_cnt;
      case (r_state)
         IDLE: begin
            if (dram_valid || dram_written) w_err_st_nxt = 1'b1;
            if (w_any) begin
               w_port_nxt       = w_gnt;
               w_is_wr_nxt      = |w_gnt_we;
               w_addr_nxt       = w_addr_v[w_gnt];
               w_wdata_nxt      = w_wdata_v[w_gnt];
               w_we_nxt         = w_gnt_we;
               w_oe_nxt         = 1'b1;
               w_wd_nxt         = '0;
               w_cnt_nxt[w_gnt] = r_cnt[w_gnt] + DW'(1);
               w_state_nxt      = WAIT;
            end
         end
         WAIT: begin
            if (w_wrong) w_err_st_nxt = 1'b1;
            if (w_match || w_timeout) begin
               w_state_nxt = DONE;
               if (!w_match) w_err_to_nxt = 1'b1;
               if (r_is_wr) begin
                  w_written_nxt[r_port] = 1'b1;
               end else begin
                  w_valid_nxt[r_port] = 1'b1;
                  w_rdata_nxt         = w_match ? dram_rdata : DEAD_DATA;
               end
            end else begin
               w_wd_nxt = r_wd + WD_W'(1);
            end
         end
         DONE: begin
            if (dram_valid || dram_written) w_err_st_nxt = 1'b1;
            w_ptr_nxt   = (r_port == PORT_DBG) ? PORT_IC : r_port + 2'd1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign rdata       = r_rdata;
   assign valid       = r_valid;
   assign written     = r_written;
   assign dram_oe     = r_oe;
   assign dram_addr   = r_addr;
   assign dram_wdata  = r_wdata;
   assign dram_we     = r_we;
   assign err_timeout = r_err_to;
   assign err_stray   = r_err_st;
   assign grant_cnt   = r_cnt;

endmodule
